// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer.
// Carries a control bundle and a data bundle between two stages over a
// valid/ready handshake. in_ready is decoded from registered state only, so
// there is no combinational path from out_ready back to in_ready, and the
// stage still moves one entry per cycle. Also provides a synchronous flush
// and a saturating count of stalled output cycles.
module pipe_stage_skid #(
  parameter int                 CTRL_W      = 10,
  parameter int                 DATA_W      = 138,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // EMPTY: nothing held; ONE: main register valid; TWO: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_reg;
  state_t              state_next;
  logic [CTRL_W-1:0]   m_ctrl_reg;
  logic [DATA_W-1:0]   m_data_reg;
  logic [CTRL_W-1:0]   s_ctrl_reg;
  logic [DATA_W-1:0]   s_data_reg;
  logic [CNT_W-1:0]    stall_cnt_reg;
  logic                m_load_in;
  logic                m_load_skid;
  logic                s_load_in;

  // Handshake outputs come straight from registered state.
  assign in_ready  = (state_reg != ST_TWO);
  assign out_valid = (state_reg != ST_EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl_reg : BUBBLE_CTRL;
  assign out_data  = m_data_reg;
  assign stall_cnt = stall_cnt_reg;

  // Next-state and storage-load decode; flush overrides every transition.
  always_comb begin
    state_next  = state_reg;
    m_load_in   = 1'b0;
    m_load_skid = 1'b0;
    s_load_in   = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_valid) begin
            state_next = ST_ONE;
            m_load_in  = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            // Back-to-back: the outgoing entry is replaced in the same cycle.
            m_load_in = 1'b1;
          end else if (in_valid) begin
            // Downstream stalled: park the new entry in the skid register.
            state_next = ST_TWO;
            s_load_in  = 1'b1;
          end else if (out_ready) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so the input is not looked at.
          if (out_ready) begin
            state_next  = ST_ONE;
            m_load_skid = 1'b1;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Main and skid registers; written only on the loads decoded above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl_reg <= BUBBLE_CTRL;
      m_data_reg <= '0;
      s_ctrl_reg <= BUBBLE_CTRL;
      s_data_reg <= '0;
    end else begin
      if (m_load_in) begin
        m_ctrl_reg <= in_ctrl;
        m_data_reg <= in_data;
      end else if (m_load_skid) begin
        m_ctrl_reg <= s_ctrl_reg;
        m_data_reg <= s_data_reg;
      end
      if (s_load_in) begin
        s_ctrl_reg <= in_ctrl;
        s_data_reg <= in_data;
      end
    end
  end

  // Saturating count of cycles where an entry is presented but not taken.
  // Deliberately unaffected by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a queue-based model of a
// 2-deep in-order buffer checked against the DUT every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_pipe_stage_skid;

  localparam int               CTRL_W = 10;
  localparam int               DATA_W = 138;
  localparam int               CNT_W  = 4;
  localparam logic [CTRL_W-1:0] BUB   = 10'h3FF;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_skid #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_CTRL (BUB),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: in-order queue of depth 2 ----------
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t q[$];
  int   m_cnt;
  bit   m_ov;
  bit   m_ir;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cnt <= 0;
    end else begin
      m_ov = (q.size() > 0);
      m_ir = (q.size() < 2);
      if (m_ov && !out_ready && m_cnt < 15) m_cnt <= m_cnt + 1;
      if (flush) begin
        q.delete();
      end else begin
        if (m_ov && out_ready) void'(q.pop_front());
        if (in_valid && m_ir) q.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    chk("cyc_in_ready", {159'd0, in_ready}, {159'd0, (q.size() < 2)});
    chk("cyc_out_valid", {159'd0, out_valid}, {159'd0, (q.size() > 0)});
    chk("cyc_stall_cnt", {156'd0, stall_cnt}, 160'(m_cnt));
    if (q.size() > 0) begin
      chk("cyc_out_ctrl", {150'd0, out_ctrl}, {150'd0, q[0].c});
      chk("cyc_out_data", {22'd0, out_data}, {22'd0, q[0].d});
    end else begin
      chk("cyc_out_ctrl_bubble", {150'd0, out_ctrl}, {150'd0, BUB});
    end
  end

  // Record every entry the DUT hands downstream.
  logic [DATA_W-1:0] got[$];
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    // Reset values
    chk("rst_in_ready", {159'd0, in_ready}, 160'd1);
    chk("rst_out_valid", {159'd0, out_valid}, 160'd0);
    chk("rst_out_ctrl", {150'd0, out_ctrl}, 160'h3FF);
    chk("rst_out_data", {22'd0, out_data}, 160'd0);
    chk("rst_stall_cnt", {156'd0, stall_cnt}, 160'd0);
    rst = 1'b0;
    step();
    chk("idle_out_ctrl", {150'd0, out_ctrl}, 160'h3FF);

    // Stream 1..4 with downstream always ready
    got.delete();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i), CTRL_W'(i + 16), 1'b1, 1'b0);
      chk("stream_in_ready", {159'd0, in_ready}, 160'd1);
      step();
      chk("stream_out_valid", {159'd0, out_valid}, 160'd1);
      chk("stream_out_data", {22'd0, out_data}, 160'(i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("stream_drained", {159'd0, out_valid}, 160'd0);
    chk("stream_stall", {156'd0, stall_cnt}, 160'd0);
    chk("stream_count", 160'(got.size()), 160'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stream_order", {22'd0, got[i]}, 160'(i + 1));

    // Bubble control around a single entry
    drive(1'b1, 138'h55, 10'h055, 1'b1, 1'b0);
    step();
    chk("bubble_ctrl_entry", {150'd0, out_ctrl}, 160'h055);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("bubble_ctrl_after", {150'd0, out_ctrl}, 160'h3FF);

    // Backpressure fill to TWO
    got.delete();
    drive(1'b1, 138'd1, 10'd17, 1'b0, 1'b0);
    step();
    drive(1'b1, 138'd2, 10'd18, 1'b0, 1'b0);
    step();
    drive(1'b1, 138'd3, 10'd19, 1'b0, 1'b0);
    step();
    step();
    chk("bp_in_ready", {159'd0, in_ready}, 160'd0);
    chk("bp_out_data", {22'd0, out_data}, 160'd1);
    chk("bp_stall", {156'd0, stall_cnt}, 160'd3);
    drive(1'b1, 138'd3, 10'd19, 1'b1, 1'b0);
    step();
    chk("bp_out2", {22'd0, out_data}, 160'd2);
    chk("bp_in_ready_again", {159'd0, in_ready}, 160'd1);
    step();
    chk("bp_out3", {22'd0, out_data}, 160'd3);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("bp_count", 160'(got.size()), 160'd3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_order", {22'd0, got[i]}, 160'(i + 1));

    // Flush while in TWO, with entry 7 offered in the flush cycle
    got.delete();
    drive(1'b1, 138'd5, 10'd21, 1'b0, 1'b0);
    step();
    drive(1'b1, 138'd6, 10'd22, 1'b0, 1'b0);
    step();
    drive(1'b1, 138'd7, 10'd23, 1'b0, 1'b1);
    step();
    chk("flush_out_valid", {159'd0, out_valid}, 160'd0);
    chk("flush_out_ctrl", {150'd0, out_ctrl}, 160'h3FF);
    chk("flush_in_ready", {159'd0, in_ready}, 160'd1);
    chk("flush_stall", {156'd0, stall_cnt}, 160'd5);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    step();
    chk("flush_nothing_out", 160'(got.size()), 160'd0);

    // Stall counter saturation
    drive(1'b1, 138'd8, 10'd24, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (20) step();
    chk("sat_stall", {156'd0, stall_cnt}, 160'd15);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    chk("sat_after_flush", {156'd0, stall_cnt}, 160'd15);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("sat_rst_clears", {156'd0, stall_cnt}, 160'd0);
    step();
    rst = 1'b0;
    step();

    // Asynchronous reset between edges while in TWO
    drive(1'b1, 138'd9, 10'd25, 1'b0, 1'b0);
    step();
    drive(1'b1, 138'd10, 10'd26, 1'b0, 1'b0);
    step();
    chk("async_pre_in_ready", {159'd0, in_ready}, 160'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_in_ready", {159'd0, in_ready}, 160'd1);
    chk("async_out_valid", {159'd0, out_valid}, 160'd0);
    chk("async_out_ctrl", {150'd0, out_ctrl}, 160'h3FF);
    chk("async_out_data", {22'd0, out_data}, 160'd0);
    chk("async_stall", {156'd0, stall_cnt}, 160'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b1, 138'd11, 10'd27, 1'b1, 1'b0);
    step();
    chk("async_first_valid", {159'd0, out_valid}, 160'd1);
    chk("async_first_data", {22'd0, out_data}, 160'd11);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("async_drained", {159'd0, out_valid}, 160'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register; the successor to the fixed-width ID/EX-style stage registers.
- Carries a control bundle and a data bundle between two pipeline stages using a valid/ready handshake.
- Has a 2-entry skid buffer, so in_ready is a pure function of registered state with no combinational path from out_ready. Sustains full throughput.
- Adds synchronous flush (bubble insertion) and a saturating stall-cycle counter. Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- CTRL_W, 10, width of the control bundle (reg_dst, write_regf, aluop, ...).
- DATA_W, 138, width of the data bundle (pc, operands, immediate, register indices).
- BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented whenever no valid entry is at the output.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- out_valid  output  1  stage presents an entry.
- out_ready  input  1  downstream accepts the entry this cycle.
- out_ctrl  output  CTRL_W  control bundle; equals BUBBLE_CTRL when out_valid=0.
- out_data  output  DATA_W  data bundle; meaningful only when out_valid=1.
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage and state
  - Storage is a main register (M) and a skid register (S), each holding ctrl+data.
  - State is one of EMPTY (no entries), ONE (M valid), TWO (M and S valid).
- Handshake definitions
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state != TWO); decoded from registered state only.
  - out_valid = (state != EMPTY).
  - out_ctrl = out_valid ? M.ctrl : BUBBLE_CTRL.
  - out_data = M.data.
- Transitions (flush=0)
  - EMPTY, in_valid=1: go to ONE, M<=in.
  - EMPTY, in_valid=0: stay EMPTY.
  - ONE, in_fire & out_fire: stay ONE, M<=in (back-to-back, 1 entry/cycle).
  - ONE, in_fire & !out_ready: go to TWO, S<=in, M unchanged.
  - ONE, !in_valid & out_fire: go to EMPTY.
  - ONE, no activity: hold.
  - TWO, out_fire: go to ONE, M<=S. Input is ignored because in_ready=0.
  - TWO, !out_ready: hold.
- Ordering and latency
  - Entries leave in arrival order; none is dropped or duplicated unless flushed.
  - Latency is 1 cycle: an entry accepted at edge N is on out_* after edge N.
- Flush
  - Highest priority after reset: the next state is EMPTY regardless of in_valid or out_ready.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - A downstream handshake in the flush cycle still counts as consumed.
  - M and S data are not cleared. out_ctrl reads BUBBLE_CTRL from the next cycle because out_valid=0.
- Stall counter
  - Increments when out_valid & !out_ready, saturating at 2^CNT_W-1.
  - Not cleared by flush; cleared only by rst.
- Reset
  - Asynchronous, active-high, taking effect immediately.
  - state=EMPTY, M and S ctrl=BUBBLE_CTRL, M and S data=0, stall_cnt=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0.
  - Reset asserted mid-operation discards all entries. The first edge after deassertion behaves as from EMPTY.
- Boundary conditions
  - in_valid may deassert at any time without having been accepted.
  - out_valid is never withdrawn without out_fire or flush.
  - M and S are only written on the transitions listed above.

Test Plan:
- Reset then stream: hold rst, then release; in_valid=1 for 4 cycles with data 1,2,3,4; out_ready=1 -> in_ready=1 throughout; out_data 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance; stall_cnt=0.
- Backpressure fill: after 1 and 2 are accepted, set out_ready=0 for 3 cycles with in_valid=1 and data 3 waiting -> state TWO; in_ready=0; out_data holds 1; stall_cnt=3. Raise out_ready -> out 2, then 3; no loss.
- Flush in TWO: fill with 5,6 and hold out_ready=0; pulse flush with in_valid=1 carrying 7 -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1. Entry 7 never appears on the output.
- Bubble control: set BUBBLE_CTRL=10'h3FF and leave the stage idle after reset -> out_ctrl=10'h3FF. Push ctrl 10'h055 -> out_ctrl=10'h055 for one cycle, then 10'h3FF again.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. Flush -> stays 15. rst -> 0.
- Async reset mid-stream: assert rst between clock edges while in TWO -> outputs return to reset values immediately, before the next edge. The first entry after deassertion emerges 1 cycle after acceptance.
